// File: rtl/hc4_periph_pkg.sv
// Shared constants for HC4 nibble-bus peripherals: register offsets,
// STATUS bit positions and the transmitter state encoding.
package hc4_periph_pkg;

    localparam logic [1:0] TX_LO  = 2'd0;
    localparam logic [1:0] TX_HI  = 2'd1;
    localparam logic [1:0] STATUS = 2'd2;
    localparam logic [1:0] COUNT  = 2'd3;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // FIFO occupancy width; DEPTH never exceeds 7.
    localparam int CNT_W = 3;

    function automatic logic [3:0] pack_status(input logic busy, input logic full,
                                               input logic empty, input logic ovf);
        logic [3:0] s;
        s           = 4'h0;
        s[ST_BUSY]  = busy;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        s[ST_OVF]   = ovf;
        return s;
    endfunction

endpackage

// File: rtl/hc4_byte_fifo.sv
// Synchronous byte FIFO with modulo-DEPTH pointers, so non power-of-two
// depths wrap correctly. Push when full and pop when empty are ignored.
module hc4_byte_fifo
    import hc4_periph_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [7:0]       mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/hc4_uart_tx.sv
// Memory-mapped 8N1 transmitter on the HC4 nibble bus: bus decode, write
// edge detect, staged low nibble, sticky overflow and the serial shifter.
module hc4_uart_tx
    import hc4_periph_pkg::*;
#(
    parameter logic [7:0] BASE         = 8'hF0,
    parameter int         DEPTH        = 4,
    parameter int         CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [7:0] address_bus,
    inout  wire  [3:0] data_bus,
    input  logic       nRAM_RD,
    input  logic       nRAM_WR,
    output logic       txd,
    output logic       busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    logic             wr_q;
    logic [3:0]       stage_q;
    logic             ovf_q;
    logic [1:0]       state_q, state_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;

    logic             in_win;
    logic [1:0]       offset;
    logic             wr_ev;
    logic             baud_done;
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       rd_data;

    assign in_win    = (address_bus[7:2] == BASE[7:2]);
    assign offset    = address_bus[1:0];
    // Only the falling strobe edge counts, so a held strobe writes once.
    assign wr_ev     = in_win && !nRAM_WR && wr_q;
    assign fifo_push = wr_ev && (offset == TX_HI) && !fifo_full;
    assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;
    assign baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));

    hc4_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .Reset (Reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({data_bus, stage_q}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_q    <= 1'b0;
            stage_q <= 4'h0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q <= nRAM_WR;
            if (wr_ev && (offset == TX_LO)) begin
                stage_q <= data_bus;
            end
            if (wr_ev && (offset == TX_HI) && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (wr_ev && (offset == STATUS) && data_bus[3]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_START;
                    shift_d = fifo_dout;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign busy = (state_q != S_IDLE) || !fifo_empty;
    assign txd  = txd_q;

    always_comb begin
        rd_data = 4'h0;
        case (offset)
            TX_LO:  rd_data = stage_q;
            TX_HI:  rd_data = 4'h0;
            STATUS: rd_data = pack_status(busy, fifo_full, fifo_empty, ovf_q);
            COUNT:  rd_data = {1'b0, fifo_count};
        endcase
    end

    assign data_bus = (in_win && !nRAM_RD) ? rd_data : 4'bz;

endmodule

// File: tb/tb_hc4_uart_tx.sv
// Bench for hc4_uart_tx: register table, hand-written timing sequences and
// random traffic checked every cycle against a frame-schedule model.
module tb_hc4_uart_tx;

    localparam int DEPTH = 4;
    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk         = 1'b0;
    logic       Reset       = 1'b1;
    logic [7:0] address_bus = 8'h00;
    logic       nRAM_RD     = 1'b1;
    logic       nRAM_WR     = 1'b1;
    logic [3:0] tb_data     = 4'h0;
    logic       tb_drive    = 1'b0;
    wire  [3:0] data_bus;
    logic       txd;
    logic       busy;

    assign data_bus = tb_drive ? tb_data : 4'bz;

    // Undriven bus floats to 4'hF so a stray DUT driver is visible.
    for (genvar g = 0; g < 4; g++) begin : g_pu
        pullup pu (data_bus[g]);
    end

    hc4_uart_tx #(.BASE(8'hF0), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .address_bus (address_bus),
        .data_bus    (data_bus),
        .nRAM_RD     (nRAM_RD),
        .nRAM_WR     (nRAM_WR),
        .txd         (txd),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: schedule of accepted bytes ----------
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         push_q[$];
    int         start_q[$];
    logic [3:0] m_stage = 4'h0;
    logic       m_ovf = 1'b0;
    int         last_start = -1000;
    logic       pend_lo = 1'b0, pend_hi = 1'b0, pend_clr = 1'b0;
    logic [3:0] pend_data = 4'h0;
    int         checks = 0;
    int         failures = 0;

    function automatic int m_count(input int t);
        int n = 0;
        foreach (push_q[i]) if (push_q[i] <= t && start_q[i] > t) n++;
        return n;
    endfunction

    function automatic logic m_busy(input int t);
        foreach (push_q[i]) if (push_q[i] <= t && t < start_q[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_txd(input int t);
        int k;
        foreach (start_q[i]) begin
            if (start_q[i] <= t && t < start_q[i] + FRAME) begin
                k = (t - start_q[i]) / CPB;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return exp_q[i][k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_status(input int t);
        int n;
        n = m_count(t);
        return {m_ovf, (n == 0), (n == DEPTH), m_busy(t)};
    endfunction

    function automatic void m_push(input int p, input logic [7:0] b);
        int s;
        if (m_count(p - 1) >= DEPTH) begin
            m_ovf = 1'b1;
        end else begin
            s = (p + 1 > last_start + FRAME + 1) ? p + 1 : last_start + FRAME + 1;
            exp_q.push_back(b);
            push_q.push_back(p);
            start_q.push_back(s);
            last_start = s;
        end
    endfunction

    function automatic void m_clear();
        exp_q.delete();
        push_q.delete();
        start_q.delete();
        m_stage    = 4'h0;
        m_ovf      = 1'b0;
        last_start = -1000;
    endfunction

    // ---------------- scoreboard helpers ----------------------------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (Reset) begin
            m_clear();
        end else begin
            if (pend_lo) m_stage = pend_data;
            if (pend_hi) m_push(cyc, {pend_data, m_stage});
            if (pend_clr && pend_data[3]) m_ovf = 1'b0;
        end
        pend_lo  = 1'b0;
        pend_hi  = 1'b0;
        pend_clr = 1'b0;
        chk("txd", {7'd0, txd}, {7'd0, m_txd(cyc)});
        chk("busy", {7'd0, busy}, {7'd0, m_busy(cyc)});
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    // ---------------- driver tasks ----------------------------------------
    task automatic bus_wr(input logic [7:0] a, input logic [3:0] d);
        address_bus = a;
        tb_data     = d;
        tb_drive    = 1'b1;
        nRAM_WR     = 1'b0;
        if (a[7:2] == 6'h3C) begin
            pend_lo   = (a[1:0] == 2'd0);
            pend_hi   = (a[1:0] == 2'd1);
            pend_clr  = (a[1:0] == 2'd2);
            pend_data = d;
        end
        tick();
        nRAM_WR  = 1'b1;
        tb_drive = 1'b0;
        tick();
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [3:0] v);
        address_bus = a;
        nRAM_RD     = 1'b0;
        #1;
        v       = data_bus;
        nRAM_RD = 1'b1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic chk_regs(input string tag);
        logic [3:0] v;
        bus_rd(8'hF2, v);
        chk({tag, "_status"}, {4'h0, v}, {4'h0, m_status(cyc)});
        bus_rd(8'hF3, v);
        chk({tag, "_count"}, {4'h0, v}, 8'(m_count(cyc)));
    endtask

    typedef struct packed {
        logic       is_wr;
        logic [7:0] addr;
        logic [3:0] data;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [3:0] v;
        int         p;
        int         s;
        int         r;

        tbl[0]  = '{1'b0, 8'hF2, 4'h0, 4'h4};
        tbl[1]  = '{1'b0, 8'hF3, 4'h0, 4'h0};
        tbl[2]  = '{1'b0, 8'hF0, 4'h0, 4'h0};
        tbl[3]  = '{1'b0, 8'hF1, 4'h0, 4'h0};
        tbl[4]  = '{1'b1, 8'hF0, 4'h7, 4'h0};
        tbl[5]  = '{1'b0, 8'hF0, 4'h0, 4'h7};
        tbl[6]  = '{1'b0, 8'hEF, 4'h0, 4'hF};
        tbl[7]  = '{1'b0, 8'h10, 4'h0, 4'hF};
        tbl[8]  = '{1'b1, 8'hEC, 4'h2, 4'h0};
        tbl[9]  = '{1'b0, 8'hF0, 4'h0, 4'h7};
        tbl[10] = '{1'b1, 8'hED, 4'h5, 4'h0};
        tbl[11] = '{1'b0, 8'hF3, 4'h0, 4'h0};
        tbl[12] = '{1'b0, 8'hF2, 4'h0, 4'h4};
        tbl[13] = '{1'b1, 8'hF2, 4'h8, 4'h0};
        tbl[14] = '{1'b0, 8'hF2, 4'h0, 4'h4};
        tbl[15] = '{1'b1, 8'hF3, 4'h9, 4'h0};
        tbl[16] = '{1'b0, 8'hF3, 4'h0, 4'h0};

        // Reset state and register table.
        do_reset();
        chk("rst_txd", {7'd0, txd}, 8'h01);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        foreach (tbl[i]) begin
            if (tbl[i].is_wr) begin
                bus_wr(tbl[i].addr, tbl[i].data);
            end else begin
                bus_rd(tbl[i].addr, v);
                chk($sformatf("vec%0d_rd_%h", i, tbl[i].addr), {4'h0, v}, {4'h0, tbl[i].exp});
                tick();
            end
        end

        // Single byte 0xA5: start one edge after push, LSB first, busy drops at +161.
        do_reset();
        bus_wr(8'hF0, 4'h5);
        p = cyc + 1;
        bus_wr(8'hF1, 4'hA);
        chk("sb_start", {7'd0, txd}, 8'h00);
        wait_to(p + 16);  chk("sb_start_end", {7'd0, txd}, 8'h00);
        wait_to(p + 17);  chk("sb_bit0", {7'd0, txd}, 8'h01);
        wait_to(p + 33);  chk("sb_bit1", {7'd0, txd}, 8'h00);
        wait_to(p + 160); chk("sb_stop", {7'd0, txd}, 8'h01);
        chk("sb_busy_stop", {7'd0, busy}, 8'h01);
        wait_to(p + 161); chk("sb_busy_done", {7'd0, busy}, 8'h00);

        // Overflow: six back-to-back bytes, five accepted.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus_wr(8'hF0, i[3:0]);
            bus_wr(8'hF1, 4'h3);
        end
        bus_rd(8'hF2, v); chk("ovf_status", {4'h0, v}, 8'h0B);
        bus_rd(8'hF3, v); chk("ovf_count", {4'h0, v}, 8'h04);
        bus_wr(8'hF2, 4'h8);
        bus_rd(8'hF2, v); chk("ovf_cleared", {4'h0, v}, 8'h03);
        wait_to(cyc + 5 * (FRAME + 1) + 10);
        bus_rd(8'hF2, v); chk("ovf_drained", {4'h0, v}, 8'h04);

        // Back-to-back: second START exactly FRAME+1 after the first.
        do_reset();
        bus_wr(8'hF0, 4'h1);
        p = cyc + 1;
        bus_wr(8'hF1, 4'h4);
        bus_wr(8'hF0, 4'h2);
        bus_wr(8'hF1, 4'h4);
        s = p + 1;
        wait_to(s + FRAME);     chk("b2b_gap_txd", {7'd0, txd}, 8'h01);
        chk("b2b_gap_busy", {7'd0, busy}, 8'h01);
        wait_to(s + FRAME + 1); chk("b2b_second_start", {7'd0, txd}, 8'h00);
        wait_to(s + 2 * FRAME + 10);

        // Held strobe: five low cycles at TX_HI give one push.
        do_reset();
        bus_wr(8'hF0, 4'h3);
        address_bus = 8'hF1;
        tb_data     = 4'h4;
        tb_drive    = 1'b1;
        nRAM_WR     = 1'b0;
        pend_hi     = 1'b1;
        pend_data   = 4'h4;
        p = cyc + 1;
        repeat (5) tick();
        nRAM_WR  = 1'b1;
        tb_drive = 1'b0;
        tick();
        bus_rd(8'hF3, v); chk("held_count", {4'h0, v}, 8'h00);
        wait_to(p + 161); chk("held_busy_done", {7'd0, busy}, 8'h00);
        wait_to(p + 400); chk("held_one_frame", {7'd0, busy}, 8'h00);

        // Strobe already low when reset releases is ignored.
        Reset       = 1'b1;
        address_bus = 8'hF1;
        tb_data     = 4'h5;
        tb_drive    = 1'b1;
        nRAM_WR     = 1'b0;
        tick();
        Reset = 1'b0;
        repeat (3) tick();
        nRAM_WR  = 1'b1;
        tb_drive = 1'b0;
        tick();
        bus_rd(8'hF3, v); chk("rstlow_count", {4'h0, v}, 8'h00);
        chk("rstlow_busy", {7'd0, busy}, 8'h00);

        // Reset during data bit 3 aborts the frame and drops the queue.
        do_reset();
        bus_wr(8'hF0, 4'h5);
        p = cyc + 1;
        bus_wr(8'hF1, 4'hA);
        bus_wr(8'hF0, 4'h1);
        bus_wr(8'hF1, 4'h2);
        s = p + 1;
        wait_to(s + 4 * CPB + 4);
        chk("mid_bit3_low", {7'd0, txd}, 8'h00);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mid_rst_txd", {7'd0, txd}, 8'h01);
        bus_rd(8'hF2, v); chk("mid_rst_status", {4'h0, v}, 8'h04);
        bus_rd(8'hF3, v); chk("mid_rst_count", {4'h0, v}, 8'h00);
        wait_to(cyc + 400);
        chk("mid_rst_quiet", {7'd0, busy}, 8'h00);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                bus_wr(8'hF0, 4'($urandom_range(0, 15)));
                bus_wr(8'hF1, 4'($urandom_range(0, 15)));
            end else if (r == 6) begin
                bus_wr(8'hF2, 4'($urandom_range(0, 15)));
            end else if (r == 7) begin
                bus_wr(8'($urandom_range(0, 1) == 0 ? 8'hEC : 8'hED), 4'($urandom_range(0, 15)));
            end else begin
                repeat ($urandom_range(1, 300)) tick();
            end
            chk_regs("rnd");
        end
        wait_to(cyc + (DEPTH + 2) * (FRAME + 1));
        chk_regs("rnd_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
